simple_tap_ctrl: RTL and testbench

- Initiator side of the tap-memory interface: drives the read, write, sub-word-write and inter strobes into the banked tap memory and consumes its full-width read data.
- Supports three operations: serial 32-bit tap load (sub-word writes that walk lanes, then addresses), sequential read sweep with aligned output, and full-width write-back.
- Sits between the stage sequencer/host loader and the tap memory of each neural stage.

---
 rtl/simple_tap_ctrl_pkg.sv | 33 +++
 rtl/simple_tap_ctrl_rdpipe.sv | 45 ++++
 rtl/simple_tap_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_simple_tap_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_tap_ctrl_pkg.sv
// Shared types and constants for the tap-memory initiator.
// The command struct mirrors the tap memory's own interface typedef.
package simple_tap_ctrl_pkg;

    localparam int TAP_LANES  = 6;
    localparam int TAP_WIDTH  = 32;
    localparam int TAP_DEPTH  = 4;
    localparam int TAP_ADDR_W = $clog2(TAP_DEPTH);
    localparam int TAP_SUB_W  = 3;
    localparam int TAP_RD_LAT = 1;
    localparam int TAP_ROW_W  = TAP_LANES * TAP_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWEEP,
        DRAIN
    } tap_ctrl_state_t;

    typedef struct packed {
        logic [TAP_ADDR_W-1:0] rd_address;
        logic                  rd_vld;
        logic [TAP_ADDR_W-1:0] wr_address;
        logic                  wr_vld;
        logic [TAP_SUB_W-1:0]  sub_addr;
        logic                  sub_vld;
        logic [TAP_WIDTH-1:0]  sub_data;
        logic                  inter;
        logic                  inter_first;
        logic [TAP_ROW_W-1:0]  wr_data;
    } tap_cmd_t;

endpackage

// File: rtl/simple_tap_ctrl_rdpipe.sv
// Read return path: delays {vld, addr} by the memory read latency, then
// registers them together with the returned row.
module simple_tap_ctrl_rdpipe #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 192,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_vld,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_last <= 1'b0;
            out_data <= '0;
        end else begin
            pipe_vld[0]  <= rd_vld;
            pipe_addr[0] <= rd_address;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
            out_vld  <= pipe_vld[RD_LAT-1];
            out_addr <= pipe_addr[RD_LAT-1];
            out_last <= pipe_vld[RD_LAT-1] && (pipe_addr[RD_LAT-1] == ADDR_W'(DEPTH - 1));
            if (pipe_vld[RD_LAT-1]) out_data <= rd_data;
        end
    end

endmodule

// File: rtl/simple_tap_ctrl.sv
// Tap-memory initiator: serial lane-by-lane tap load, sequential read sweep
// with aligned output, and full-width write-back.
module simple_tap_ctrl
    import simple_tap_ctrl_pkg::*;
#(
    parameter int RD_LAT = TAP_RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_vld,
    input  logic                  load_first,
    input  logic [TAP_WIDTH-1:0]  load_data,
    output logic                  load_rdy,
    output logic                  load_done,
    input  logic                  wb_vld,
    input  logic [TAP_ADDR_W-1:0] wb_addr,
    input  logic [TAP_ROW_W-1:0]  wb_data,
    output logic                  wb_rdy,
    output logic [TAP_ADDR_W-1:0] tap_rd_address,
    output logic                  tap_rd_vld,
    output logic [TAP_ADDR_W-1:0] tap_wr_address,
    output logic                  tap_wr_vld,
    output logic [TAP_SUB_W-1:0]  tap_sub_addr,
    output logic                  tap_sub_vld,
    output logic [TAP_WIDTH-1:0]  tap_sub_data,
    output logic                  tap_inter,
    output logic                  tap_inter_first,
    output logic [TAP_ROW_W-1:0]  tap_wr_data,
    input  logic [TAP_ROW_W-1:0]  tap_rd_data,
    output logic                  out_vld,
    output logic [TAP_ADDR_W-1:0] out_addr,
    output logic                  out_last,
    output logic [TAP_ROW_W-1:0]  out_data,
    output logic                  busy
);

    localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // Assertion is immediate; release is retimed to clk through two flops.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    tap_ctrl_state_t       state, state_nxt;
    tap_cmd_t              cmd_q, cmd_nxt;
    logic [TAP_SUB_W-1:0]  lane_q, lane_nxt, eff_lane;
    logic [TAP_ADDR_W-1:0] ld_addr_q, ld_addr_nxt, eff_addr;
    logic [TAP_ADDR_W-1:0] rd_ptr_q, rd_ptr_nxt;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_nxt;
    logic                  load_done_q, load_done_nxt;
    logic                  load_rdy_q, wb_rdy_q, busy_q;
    logic                  pend_q, pend_nxt;
    logic [TAP_ADDR_W-1:0] pend_addr_q;
    logic [TAP_ROW_W-1:0]  pend_data_q;
    logic                  load_acc, wb_acc, last_word;

    assign load_acc  = load_vld && load_rdy_q;
    assign wb_acc    = wb_vld && wb_rdy_q;
    assign eff_lane  = load_first ? '0 : lane_q;
    assign eff_addr  = load_first ? '0 : ld_addr_q;
    assign last_word = (eff_lane == TAP_SUB_W'(TAP_LANES - 1)) &&
                       (eff_addr == TAP_ADDR_W'(TAP_DEPTH - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt           = state;
        lane_nxt            = lane_q;
        ld_addr_nxt         = ld_addr_q;
        rd_ptr_nxt          = rd_ptr_q;
        drain_cnt_nxt       = drain_cnt_q;
        load_done_nxt       = 1'b0;
        pend_nxt            = pend_q;
        cmd_nxt             = cmd_q;
        cmd_nxt.rd_vld      = 1'b0;
        cmd_nxt.wr_vld      = 1'b0;
        cmd_nxt.sub_vld     = 1'b0;
        cmd_nxt.inter       = 1'b0;
        cmd_nxt.inter_first = 1'b0;

        case (state)
            IDLE, LOAD: begin
                if (load_acc) begin
                    if (last_word) begin
                        state_nxt     = IDLE;
                        lane_nxt      = '0;
                        ld_addr_nxt   = '0;
                        load_done_nxt = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                        if (eff_lane == TAP_SUB_W'(TAP_LANES - 1)) begin
                            lane_nxt    = '0;
                            ld_addr_nxt = eff_addr + TAP_ADDR_W'(1);
                        end else begin
                            lane_nxt    = eff_lane + TAP_SUB_W'(1);
                            ld_addr_nxt = eff_addr;
                        end
                    end
                end else if (state == IDLE && start && !load_vld) begin
                    state_nxt  = SWEEP;
                    rd_ptr_nxt = '0;
                end
            end
            SWEEP: begin
                cmd_nxt.rd_vld      = 1'b1;
                cmd_nxt.rd_address  = rd_ptr_q;
                cmd_nxt.inter       = 1'b1;
                cmd_nxt.inter_first = (rd_ptr_q == '0);
                if (rd_ptr_q == TAP_ADDR_W'(TAP_DEPTH - 1)) begin
                    state_nxt     = DRAIN;
                    rd_ptr_nxt    = '0;
                    drain_cnt_nxt = '0;
                end else begin
                    rd_ptr_nxt = rd_ptr_q + TAP_ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(RD_LAT - 1)) begin
                    state_nxt     = IDLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A write-back that lands in the same IDLE cycle as a load word is
        // parked and issued on the first cycle without a lane write.
        if (load_acc) begin
            cmd_nxt.sub_vld    = 1'b1;
            cmd_nxt.sub_addr   = eff_lane;
            cmd_nxt.sub_data   = load_data;
            cmd_nxt.wr_address = eff_addr;
            if (wb_acc) pend_nxt = 1'b1;
        end else if (pend_q) begin
            cmd_nxt.wr_vld     = 1'b1;
            cmd_nxt.wr_address = pend_addr_q;
            cmd_nxt.wr_data    = pend_data_q;
            pend_nxt           = 1'b0;
        end else if (wb_acc) begin
            cmd_nxt.wr_vld     = 1'b1;
            cmd_nxt.wr_address = wb_addr;
            cmd_nxt.wr_data    = wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_q       <= '0;
            lane_q      <= '0;
            ld_addr_q   <= '0;
            rd_ptr_q    <= '0;
            drain_cnt_q <= '0;
            load_done_q <= 1'b0;
            load_rdy_q  <= 1'b0;
            wb_rdy_q    <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_q       <= cmd_nxt;
            lane_q      <= lane_nxt;
            ld_addr_q   <= ld_addr_nxt;
            rd_ptr_q    <= rd_ptr_nxt;
            drain_cnt_q <= drain_cnt_nxt;
            load_done_q <= load_done_nxt;
            load_rdy_q  <= (state_nxt == IDLE) || (state_nxt == LOAD);
            wb_rdy_q    <= (state_nxt != LOAD) && !pend_nxt;
            busy_q      <= (state_nxt != IDLE);
            pend_q      <= pend_nxt;
        end
    end

    // NOTE: payload registers carry no reset; pend_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (load_acc && wb_acc) begin
            pend_addr_q <= wb_addr;
            pend_data_q <= wb_data;
        end
    end

    simple_tap_ctrl_rdpipe #(
        .ADDR_W (TAP_ADDR_W),
        .DATA_W (TAP_ROW_W),
        .DEPTH  (TAP_DEPTH),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk        (clk),
        .reset      (rst_n),
        .rd_vld     (cmd_q.rd_vld),
        .rd_address (cmd_q.rd_address),
        .rd_data    (tap_rd_data),
        .out_vld    (out_vld),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .out_data   (out_data)
    );

    assign tap_rd_address  = cmd_q.rd_address;
    assign tap_rd_vld      = cmd_q.rd_vld;
    assign tap_wr_address  = cmd_q.wr_address;
    assign tap_wr_vld      = cmd_q.wr_vld;
    assign tap_sub_addr    = cmd_q.sub_addr;
    assign tap_sub_vld     = cmd_q.sub_vld;
    assign tap_sub_data    = cmd_q.sub_data;
    assign tap_inter       = cmd_q.inter;
    assign tap_inter_first = cmd_q.inter_first;
    assign tap_wr_data     = cmd_q.wr_data;
    assign load_done       = load_done_q;
    assign load_rdy        = load_rdy_q;
    assign wb_rdy          = wb_rdy_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_simple_tap_ctrl.sv
// Directed bench for simple_tap_ctrl with a behavioural RD_LAT=1 tap memory
// and an independently maintained expected memory image.
module tb_simple_tap_ctrl;

    localparam int LANES  = 6;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int RW     = LANES * WIDTH;

    logic              clk;
    logic              reset;
    logic              start;
    logic              load_vld;
    logic              load_first;
    logic [WIDTH-1:0]  load_data;
    logic              load_rdy;
    logic              load_done;
    logic              wb_vld;
    logic [ADDR_W-1:0] wb_addr;
    logic [RW-1:0]     wb_data;
    logic              wb_rdy;
    logic [ADDR_W-1:0] tap_rd_address;
    logic              tap_rd_vld;
    logic [ADDR_W-1:0] tap_wr_address;
    logic              tap_wr_vld;
    logic [2:0]        tap_sub_addr;
    logic              tap_sub_vld;
    logic [WIDTH-1:0]  tap_sub_data;
    logic              tap_inter;
    logic              tap_inter_first;
    logic [RW-1:0]     tap_wr_data;
    logic [RW-1:0]     tap_rd_data;
    logic              out_vld;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic [RW-1:0]     out_data;
    logic              busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [RW-1:0] mem     [DEPTH];
    logic [RW-1:0] exp_mem [DEPTH];

    simple_tap_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .load_vld        (load_vld),
        .load_first      (load_first),
        .load_data       (load_data),
        .load_rdy        (load_rdy),
        .load_done       (load_done),
        .wb_vld          (wb_vld),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .wb_rdy          (wb_rdy),
        .tap_rd_address  (tap_rd_address),
        .tap_rd_vld      (tap_rd_vld),
        .tap_wr_address  (tap_wr_address),
        .tap_wr_vld      (tap_wr_vld),
        .tap_sub_addr    (tap_sub_addr),
        .tap_sub_vld     (tap_sub_vld),
        .tap_sub_data    (tap_sub_data),
        .tap_inter       (tap_inter),
        .tap_inter_first (tap_inter_first),
        .tap_wr_data     (tap_wr_data),
        .tap_rd_data     (tap_rd_data),
        .out_vld         (out_vld),
        .out_addr        (out_addr),
        .out_last        (out_last),
        .out_data        (out_data),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tap memory, one cycle read latency.
    always @(posedge clk) begin
        if (tap_sub_vld) mem[tap_wr_address][int'(tap_sub_addr)*WIDTH +: WIDTH] <= tap_sub_data;
        if (tap_wr_vld)  mem[tap_wr_address] <= tap_wr_data;
        if (tap_rd_vld)  tap_rd_data <= mem[tap_rd_address];
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] data, input logic first,
                             input int lane, input int addr, input logic done);
        load_vld   = 1'b1;
        load_data  = data;
        load_first = first;
        step();
        load_vld   = 1'b0;
        load_first = 1'b0;
        check("sub_vld",   RW'(tap_sub_vld),    RW'(1));
        check("sub_addr",  RW'(tap_sub_addr),   RW'(lane));
        check("wr_addr",   RW'(tap_wr_address), RW'(addr));
        check("sub_data",  RW'(tap_sub_data),   RW'(data));
        check("wr_vld_ld", RW'(tap_wr_vld),     RW'(0));
        check("load_done", RW'(load_done),      RW'(done));
        check("busy_ld",   RW'(busy),           RW'(!done));
        exp_mem[addr][lane*WIDTH +: WIDTH] = data;
    endtask

    task automatic run_sweep(input logic with_wb);
        logic [RW-1:0] pat;
        pat   = {24{8'h5A}};
        start = 1'b1;
        step();
        start = 1'b0;
        check("sw_busy0", RW'(busy),       RW'(1));
        check("sw_rd0",   RW'(tap_rd_vld), RW'(0));
        if (with_wb) begin
            wb_vld  = 1'b1;
            wb_addr = 2'd2;
            wb_data = pat;
        end
        for (int j = 1; j <= 7; j++) begin
            step();
            if (j == 1 && with_wb) begin
                wb_vld     = 1'b0;
                exp_mem[2] = pat;
                check("wb_vld",   RW'(tap_wr_vld),     RW'(1));
                check("wb_addr",  RW'(tap_wr_address), RW'(2));
                check("wb_data",  tap_wr_data,         pat);
                check("wb_sub",   RW'(tap_sub_vld),    RW'(0));
            end else begin
                check("sw_wr_vld", RW'(tap_wr_vld), RW'(0));
            end
            check("rd_vld", RW'(tap_rd_vld), RW'(j <= 4));
            check("inter",  RW'(tap_inter),  RW'(j <= 4));
            if (j <= 4) begin
                check("rd_addr",     RW'(tap_rd_address),  RW'(j - 1));
                check("inter_first", RW'(tap_inter_first), RW'(j == 1));
            end
            check("sw_busy", RW'(busy),    RW'(j <= 4));
            check("out_vld", RW'(out_vld), RW'(j >= 3 && j <= 6));
            if (j >= 3 && j <= 6) begin
                check("out_addr", RW'(out_addr), RW'(j - 3));
                check("out_last", RW'(out_last), RW'(j == 6));
                check("out_data", out_data,      exp_mem[j-3]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        load_vld   = 1'b0;
        load_first = 1'b0;
        load_data  = '0;
        wb_vld     = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        for (int a = 0; a < DEPTH; a++) begin
            mem[a]     = '0;
            exp_mem[a] = '0;
        end

        // Reset state
        step();
        step();
        check("rst_load_rdy", RW'(load_rdy),    RW'(0));
        check("rst_wb_rdy",   RW'(wb_rdy),      RW'(0));
        check("rst_busy",     RW'(busy),        RW'(0));
        check("rst_sub_vld",  RW'(tap_sub_vld), RW'(0));
        check("rst_rd_vld",   RW'(tap_rd_vld),  RW'(0));
        check("rst_out_vld",  RW'(out_vld),     RW'(0));
        reset = 1'b1;
        repeat (4) step();
        check("idle_load_rdy", RW'(load_rdy), RW'(1));
        check("idle_wb_rdy",   RW'(wb_rdy),   RW'(1));

        // Full 24-word load, back to back
        for (int i = 0; i < LANES * DEPTH; i++)
            send_word(32'h100 + WIDTH'(i), 1'b0, i % LANES, i / LANES, i == LANES * DEPTH - 1);
        step();
        check("post_ld_sub", RW'(tap_sub_vld), RW'(0));
        check("post_ld_done", RW'(load_done),  RW'(0));

        // Plain sweep
        run_sweep(1'b0);

        // Partial load, restart with load_first, gap, complete
        for (int i = 0; i < 7; i++)
            send_word(32'h200 + WIDTH'(i), 1'b0, i % LANES, i / LANES, 1'b0);
        send_word(32'hAA, 1'b1, 0, 0, 1'b0);
        repeat (2) begin
            step();
            check("gap_sub", RW'(tap_sub_vld), RW'(0));
            check("gap_busy", RW'(busy),       RW'(1));
        end
        for (int i = 1; i < LANES * DEPTH; i++)
            send_word(32'h300 + WIDTH'(i), 1'b0, i % LANES, i / LANES, i == LANES * DEPTH - 1);

        // load_vld together with start; write-back held off during LOAD
        start = 1'b1;
        send_word(32'h400, 1'b0, 0, 0, 1'b0);
        start = 1'b0;
        check("ld_start_rd", RW'(tap_rd_vld), RW'(0));
        check("ld_wb_rdy",   RW'(wb_rdy),     RW'(0));
        wb_vld  = 1'b1;
        wb_addr = 2'd1;
        wb_data = {6{32'hC0DE_0001}};
        for (int i = 1; i < LANES * DEPTH; i++) begin
            send_word(32'h400 + WIDTH'(i), 1'b0, i % LANES, i / LANES, i == LANES * DEPTH - 1);
            check("ld_wb_rdy_i", RW'(wb_rdy),     RW'(i == LANES * DEPTH - 1));
            check("ld_rd_i",     RW'(tap_rd_vld), RW'(0));
        end
        step();
        wb_vld = 1'b0;
        check("wb1_vld",  RW'(tap_wr_vld),     RW'(1));
        check("wb1_addr", RW'(tap_wr_address), RW'(1));
        check("wb1_data", tap_wr_data,         {6{32'hC0DE_0001}});
        check("wb1_sub",  RW'(tap_sub_vld),    RW'(0));
        check("wb1_busy", RW'(busy),           RW'(0));
        check("wb1_rd",   RW'(tap_rd_vld),     RW'(0));
        exp_mem[1] = {6{32'hC0DE_0001}};
        step();

        // Write-back concurrent with a sweep
        run_sweep(1'b1);

        // Reset mid-sweep after the addr-1 read
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_rd_addr", RW'(tap_rd_address), RW'(1));
        reset = 1'b0;
        #1;
        check("ab_rd_vld",   RW'(tap_rd_vld),     RW'(0));
        check("ab_rd_addr",  RW'(tap_rd_address), RW'(0));
        check("ab_inter",    RW'(tap_inter),      RW'(0));
        check("ab_busy",     RW'(busy),           RW'(0));
        check("ab_load_rdy", RW'(load_rdy),       RW'(0));
        check("ab_wb_rdy",   RW'(wb_rdy),         RW'(0));
        check("ab_out_vld",  RW'(out_vld),        RW'(0));
        check("ab_out_data", out_data,            RW'(0));
        repeat (3) begin
            step();
            check("ab_hold_out", RW'(out_vld), RW'(0));
        end
        reset = 1'b1;
        repeat (4) begin
            step();
            check("ab_rel_out", RW'(out_vld),    RW'(0));
            check("ab_rel_rd",  RW'(tap_rd_vld), RW'(0));
        end
        run_sweep(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
